// File: rtl/sar_timer_pkg.sv
// ---------------------------------------------------------------------------
// sar_timer_pkg
// Shared definitions for the SAR conversion-duration timer:
//   - default TIMER / CHANNELS widths
//   - SAR StateP encodings (ST_IDLE = 00, ST_DONE = 11, the rest mean "converting")
//   - flag_decode(): conversion-active decode of one channel's state/step inputs
// ---------------------------------------------------------------------------
package sar_timer_pkg;

  localparam int TIMER_DEFAULT    = 8;
  localparam int CHANNELS_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CONV1 = 2'b01,
    ST_CONV2 = 2'b10,
    ST_DONE  = 2'b11
  } sar_state_e;

  // In idle, a pending step request (Inc or Dcr) counts as conversion activity;
  // in done nothing is active; both intermediate states are always active.
  function automatic logic flag_decode(input logic [1:0] state,
                                       input logic       inc,
                                       input logic       dcr);
    logic flag;
    case (sar_state_e'(state))
      ST_IDLE: flag = inc | dcr;
      ST_DONE: flag = 1'b0;
      default: flag = 1'b1;
    endcase
    return flag;
  endfunction

endpackage

// File: rtl/sar_chan_timer.sv
// ---------------------------------------------------------------------------
// sar_chan_timer
// One channel of the conversion timer: flag decode, edge detect, saturating
// duration counter, one-deep result holding register with pending and
// sticky dropped flags. With SAR_TIMER_MAX_EN defined it also tracks the
// largest captured duration.
// Ports:
//   ClockT, Reset      clock (rising edge), async active-high reset
//   state_p, inc, dcr  this channel's SAR state and step requests
//   grant              output stage is taking this channel's result this cycle
//   flag_conv          combinational conversion-active flag (0 during Reset)
//   pend               a captured result is waiting to be delivered
//   res, res_ovf       captured duration and its saturation flag
//   max_val            largest captured duration (SAR_TIMER_MAX_EN only)
//   dropped            sticky: an undelivered result was overwritten
// ---------------------------------------------------------------------------
module sar_chan_timer
  import sar_timer_pkg::*;
#(
  parameter int TIMER = TIMER_DEFAULT
) (
  input  logic             ClockT,
  input  logic             Reset,
  input  logic [1:0]       state_p,
  input  logic             inc,
  input  logic             dcr,
  input  logic             grant,
  output logic             flag_conv,
  output logic             pend,
  output logic [TIMER-1:0] res,
  output logic             res_ovf,
`ifdef SAR_TIMER_MAX_EN
  output logic [TIMER-1:0] max_val,
`endif
  output logic             dropped
);

  logic             flag_q, flag_d;
  logic [TIMER-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [TIMER-1:0] res_q, res_d;
  logic             rovf_q, rovf_d;
  logic             pend_q, pend_d;
  logic             dropped_q, dropped_d;
`ifdef SAR_TIMER_MAX_EN
  logic [TIMER-1:0] max_q, max_d;
`endif
  logic             rise, run, fall;

  assign flag_conv = Reset ? 1'b0 : flag_decode(state_p, inc, dcr);
  assign rise      = flag_conv & ~flag_q;
  assign run       = flag_conv & flag_q;
  assign fall      = ~flag_conv & flag_q;

  always_comb begin
    flag_d    = flag_conv;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_d     = res_q;
    rovf_d    = rovf_q;
    pend_d    = pend_q;
    dropped_d = dropped_q;
`ifdef SAR_TIMER_MAX_EN
    max_d     = max_q;
`endif
    if (rise) begin
      cnt_d = TIMER'(1);
      ovf_d = 1'b0;
    end else if (run) begin
      // Saturate instead of wrapping; the overflow flag records that it happened.
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + 1'b1;
    end
    if (fall) begin
      res_d  = cnt_q;
      rovf_d = ovf_q;
      // A capture always leaves a result pending, even when the old one is being
      // granted this cycle; only an overwrite of an ungranted result is a loss.
      pend_d = 1'b1;
      if (pend_q && !grant) dropped_d = 1'b1;
`ifdef SAR_TIMER_MAX_EN
      if (cnt_q > max_q) max_d = cnt_q;
`endif
    end else if (grant) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge ClockT or posedge Reset) begin
    if (Reset) begin
      flag_q    <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      res_q     <= '0;
      rovf_q    <= 1'b0;
      pend_q    <= 1'b0;
      dropped_q <= 1'b0;
`ifdef SAR_TIMER_MAX_EN
      max_q     <= '0;
`endif
    end else begin
      flag_q    <= flag_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      res_q     <= res_d;
      rovf_q    <= rovf_d;
      pend_q    <= pend_d;
      dropped_q <= dropped_d;
`ifdef SAR_TIMER_MAX_EN
      max_q     <= max_d;
`endif
    end
  end

  assign pend    = pend_q;
  assign res     = res_q;
  assign res_ovf = rovf_q;
  assign dropped = dropped_q;
`ifdef SAR_TIMER_MAX_EN
  assign max_val = max_q;
`endif

endmodule

// File: rtl/sar_conv_timer.sv
// ---------------------------------------------------------------------------
// sar_conv_timer
// Multi-channel conversion-duration timer. Each channel measures how many
// ClockT edges its conversion-active flag was sampled high; completed
// measurements are delivered one at a time through a shared Ready/Ack port
// chosen round-robin among pending channels.
// Optional feature macro: SAR_TIMER_MAX_EN adds per-channel maximum tracking
// and the MaxOut port.
// Ports:
//   ClockT, Reset      clock (rising edge), async active-high reset
//   StateP             per-channel SAR state, channel c at [2c+1:2c]
//   Inc, Dcr           per-channel step requests
//   Ack                controller accepts the presented result
//   FlagConv           combinational conversion-active flags
//   Ready              result valid on ChanOut/TimerOut/Overflow(/MaxOut)
//   ChanOut            channel of the presented result
//   TimerOut, Overflow measured duration and saturation flag
//   MaxOut             largest duration seen on ChanOut (SAR_TIMER_MAX_EN)
//   Dropped            sticky per-channel result-loss flags
// ---------------------------------------------------------------------------
module sar_conv_timer
  import sar_timer_pkg::*;
#(
  parameter int  TIMER    = TIMER_DEFAULT,
  parameter int  CHANNELS = CHANNELS_DEFAULT,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  ClockT,
  input  logic                  Reset,
  input  logic [2*CHANNELS-1:0] StateP,
  input  logic [CHANNELS-1:0]   Inc,
  input  logic [CHANNELS-1:0]   Dcr,
  input  logic                  Ack,
  output logic [CHANNELS-1:0]   FlagConv,
  output logic                  Ready,
  output logic [CW-1:0]         ChanOut,
  output logic [TIMER-1:0]      TimerOut,
  output logic                  Overflow,
`ifdef SAR_TIMER_MAX_EN
  output logic [TIMER-1:0]      MaxOut,
`endif
  output logic [CHANNELS-1:0]   Dropped
);

  logic [CHANNELS-1:0] pend, res_ovf, grant;
  logic [TIMER-1:0]    res [CHANNELS];
`ifdef SAR_TIMER_MAX_EN
  logic [TIMER-1:0]    max_val [CHANNELS];
  logic [TIMER-1:0]    max_out_q, max_out_d;
`endif
  logic                ready_q, ready_d;
  logic [CW-1:0]       chan_q, chan_d;
  logic [TIMER-1:0]    timer_q, timer_d;
  logic                ovf_q, ovf_d;
  logic [CW-1:0]       ptr_q, ptr_d;     // first channel to consider at the next load
  logic                found;
  logic [CW-1:0]       sel, cand_idx;
  int                  cand;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    sar_chan_timer #(.TIMER(TIMER)) u_chan (
      .ClockT   (ClockT),
      .Reset    (Reset),
      .state_p  (StateP[2*c +: 2]),
      .inc      (Inc[c]),
      .dcr      (Dcr[c]),
      .grant    (grant[c]),
      .flag_conv(FlagConv[c]),
      .pend     (pend[c]),
      .res      (res[c]),
      .res_ovf  (res_ovf[c]),
`ifdef SAR_TIMER_MAX_EN
      .max_val  (max_val[c]),
`endif
      .dropped  (Dropped[c])
    );
  end

  // Handshake: Ready=1 means ChanOut/TimerOut/Overflow(/MaxOut) hold a valid
  // result and stay frozen until a cycle with Ack=1 consumes it. In any cycle
  // where the stage is empty (Ready=0) or being consumed (Ready=1, Ack=1) the
  // next pending channel is loaded; Ack while Ready=0 has no effect.
  always_comb begin
    ready_d   = ready_q;
    chan_d    = chan_q;
    timer_d   = timer_q;
    ovf_d     = ovf_q;
    ptr_d     = ptr_q;
`ifdef SAR_TIMER_MAX_EN
    max_out_d = max_out_q;
`endif
    grant     = '0;
    found     = 1'b0;
    sel       = '0;
    cand      = 0;
    cand_idx  = '0;
    if (!ready_q || Ack) begin
      // Round-robin scan starting at ptr_q, wrapping at CHANNELS.
      for (int i = 0; i < CHANNELS; i++) begin
        cand = int'(ptr_q) + i;
        if (cand >= CHANNELS) cand = cand - CHANNELS;
        cand_idx = CW'(cand);
        if (!found && pend[cand_idx]) begin
          found = 1'b1;
          sel   = cand_idx;
        end
      end
      ready_d = found;
      if (found) begin
        grant[sel] = 1'b1;
        chan_d     = sel;
        timer_d    = res[sel];
        ovf_d      = res_ovf[sel];
`ifdef SAR_TIMER_MAX_EN
        max_out_d  = max_val[sel];
`endif
        ptr_d      = (sel == CW'(CHANNELS - 1)) ? '0 : sel + 1'b1;
      end
    end
  end

  always_ff @(posedge ClockT or posedge Reset) begin
    if (Reset) begin
      ready_q   <= 1'b0;
      chan_q    <= '0;
      timer_q   <= '0;
      ovf_q     <= 1'b0;
      ptr_q     <= '0;
`ifdef SAR_TIMER_MAX_EN
      max_out_q <= '0;
`endif
    end else begin
      ready_q   <= ready_d;
      chan_q    <= chan_d;
      timer_q   <= timer_d;
      ovf_q     <= ovf_d;
      ptr_q     <= ptr_d;
`ifdef SAR_TIMER_MAX_EN
      max_out_q <= max_out_d;
`endif
    end
  end

  assign Ready    = ready_q;
  assign ChanOut  = chan_q;
  assign TimerOut = timer_q;
  assign Overflow = ovf_q;
`ifdef SAR_TIMER_MAX_EN
  assign MaxOut   = max_out_q;
`endif

endmodule

// File: tb/tb_sar_conv_timer.sv
// ---------------------------------------------------------------------------
// tb_sar_conv_timer
// Bench for sar_conv_timer (TIMER=4 so saturation is reachable quickly).
// A duration-level model (raw sample counts, per-channel pending slots, a
// round-robin pointer) is stepped on every rising edge; one compare process
// checks every DUT output against it on each falling edge. Directed scenarios
// add literal expectations, then a long randomized phase follows.
// Honours SAR_TIMER_MAX_EN for the MaxOut port.
// ---------------------------------------------------------------------------
module tb_sar_conv_timer;

  localparam int T    = 4;
  localparam int CH   = 4;
  localparam int CWB  = 2;
  localparam int MAXV = (1 << T) - 1;

  // clock / reset
  logic             ClockT = 1'b0;
  logic             Reset;
  logic [2*CH-1:0]  StateP;
  logic [CH-1:0]    Inc, Dcr;
  logic             Ack;
  logic [CH-1:0]    FlagConv;
  logic             Ready;
  logic [CWB-1:0]   ChanOut;
  logic [T-1:0]     TimerOut;
  logic             Overflow;
  logic [CH-1:0]    Dropped;
`ifdef SAR_TIMER_MAX_EN
  logic [T-1:0]     MaxOut;
`endif

  always #5 ClockT = ~ClockT;

  sar_conv_timer #(.TIMER(T), .CHANNELS(CH)) dut (
    .ClockT  (ClockT),
    .Reset   (Reset),
    .StateP  (StateP),
    .Inc     (Inc),
    .Dcr     (Dcr),
    .Ack     (Ack),
    .FlagConv(FlagConv),
    .Ready   (Ready),
    .ChanOut (ChanOut),
    .TimerOut(TimerOut),
    .Overflow(Overflow),
`ifdef SAR_TIMER_MAX_EN
    .MaxOut  (MaxOut),
`endif
    .Dropped (Dropped)
  );

  // behavioural model state (durations kept as unbounded integers)
  int  m_dur  [CH];
  bit  m_prev [CH];
  bit  m_pend [CH];
  int  m_pdur [CH];
  bit  m_drop [CH];
  int  m_max  [CH];
  bit  m_ready;
  int  m_chan, m_odur, m_omax, m_ptr;

  int  total_cnt = 0;
  int  pass_cnt  = 0;

  logic [CH-1:0] exp_flag, exp_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int sat(input int d);
    return (d > MAXV) ? MAXV : d;
  endfunction

  function automatic bit model_flag(input int c);
    int st;
    st = int'(StateP[2*c +: 2]);
    if (Reset) return 1'b0;
    if (st == 1 || st == 2) return 1'b1;
    if (st == 0) return Inc[c] | Dcr[c];
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_dur[c] = 0; m_prev[c] = 0; m_pend[c] = 0;
      m_pdur[c] = 0; m_drop[c] = 0; m_max[c] = 0;
    end
    m_ready = 0; m_chan = 0; m_odur = 0; m_omax = 0; m_ptr = 0;
  endtask

  // One rising edge worth of behaviour, using the inputs present at the edge.
  task automatic model_step();
    int  g;
    int  c;
    bit  f;
    if (Reset) return;
    g = -1;
    if (!m_ready || Ack) begin
      for (int i = 0; i < CH; i++) begin
        c = (m_ptr + i) % CH;
        if (g < 0 && m_pend[c]) g = c;
      end
      m_ready = (g >= 0);
      if (g >= 0) begin
        m_chan = g;
        m_odur = m_pdur[g];
        m_omax = m_max[g];
        m_ptr  = (g + 1) % CH;
      end
    end
    for (int k = 0; k < CH; k++) begin
      f = model_flag(k);
      if (f) m_dur[k] = m_prev[k] ? m_dur[k] + 1 : 1;
      if (!f && m_prev[k]) begin
        if (m_pend[k] && g != k) m_drop[k] = 1;
        m_pend[k] = 1;
        m_pdur[k] = m_dur[k];
        if (sat(m_dur[k]) > m_max[k]) m_max[k] = sat(m_dur[k]);
      end else if (g == k) begin
        m_pend[k] = 0;
      end
      m_prev[k] = f;
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge ClockT);
    model_step();
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic set_st(input int c, input logic [1:0] v);
    StateP[2*c +: 2] = v;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    model_reset();
    tick();
    tick();
    Reset = 1'b0;
  endtask

  // compare process: every output against the model on every falling edge
  always @(negedge ClockT) begin
    for (int c = 0; c < CH; c++) begin
      exp_flag[c] = model_flag(c);
      exp_drop[c] = m_drop[c];
    end
    check("flag_conv", 32'(FlagConv), 32'(exp_flag));
    check("ready",     32'(Ready),    32'(m_ready));
    check("chan_out",  32'(ChanOut),  32'(m_chan));
    check("timer_out", 32'(TimerOut), 32'(sat(m_odur)));
    check("overflow",  32'(Overflow), 32'(m_odur > MAXV));
    check("dropped",   32'(Dropped),  32'(exp_drop));
`ifdef SAR_TIMER_MAX_EN
    check("max_out",   32'(MaxOut),   32'(m_omax));
`endif
  end

  initial begin
    Reset  = 1'b1;
    StateP = '1;
    Inc    = '0;
    Dcr    = '0;
    Ack    = 1'b0;
    model_reset();
    tick();
    set_st(0, 2'b01);
    #1;
    check("lit_flag_in_reset", 32'(FlagConv), 32'h0);
    set_st(0, 2'b11);
    tick();
    Reset = 1'b0;
    tick();
    check("lit_rst_ready", 32'(Ready), 32'h0);
    check("lit_rst_timer", 32'(TimerOut), 32'h0);
    check("lit_rst_chan", 32'(ChanOut), 32'h0);
    check("lit_rst_ovf", 32'(Overflow), 32'h0);
    check("lit_rst_drop", 32'(Dropped), 32'h0);

    // ch0 converting for 5 samples, Ack held high
    Ack = 1'b1;
    set_st(0, 2'b01);
    hold(5);
    set_st(0, 2'b11);
    tick();
    check("lit_a_latency", 32'(Ready), 32'h0);
    tick();
    check("lit_a_ready", 32'(Ready), 32'h1);
    check("lit_a_chan", 32'(ChanOut), 32'h0);
    check("lit_a_timer", 32'(TimerOut), 32'd5);
    check("lit_a_ovf", 32'(Overflow), 32'h0);
    tick();
    check("lit_a_pulse_end", 32'(Ready), 32'h0);

    // ch1 high for 20 samples saturates at 15
    set_st(1, 2'b10);
    hold(20);
    set_st(1, 2'b11);
    hold(2);
    check("lit_b_chan", 32'(ChanOut), 32'h1);
    check("lit_b_timer", 32'(TimerOut), 32'd15);
    check("lit_b_ovf", 32'(Overflow), 32'h1);
    tick();

    // all channels fall together; Ack low, then round-robin delivery
    do_reset();
    Ack = 1'b0;
    StateP = 8'b10_01_10_01;
    hold(2);
    StateP = '1;
    hold(2);
    for (int i = 0; i < 3; i++) begin
      check("lit_c_hold_ready", 32'(Ready), 32'h1);
      check("lit_c_hold_chan", 32'(ChanOut), 32'h0);
      if (i < 2) tick();
    end
    Ack = 1'b1;
    for (int c = 1; c < CH; c++) begin
      tick();
      check("lit_c_rr_chan", 32'(ChanOut), 32'(c));
      check("lit_c_rr_timer", 32'(TimerOut), 32'd2);
    end
    tick();
    check("lit_c_drain", 32'(Ready), 32'h0);

    // ch2 result overwritten while the stage is blocked
    do_reset();
    Ack = 1'b0;
    set_st(0, 2'b01);
    tick();
    set_st(0, 2'b11);
    hold(2);
    check("lit_d_pulse_timer", 32'(TimerOut), 32'd1);
    set_st(2, 2'b01);
    hold(3);
    set_st(2, 2'b11);
    tick();
    set_st(2, 2'b10);
    hold(7);
    set_st(2, 2'b11);
    tick();
    check("lit_d_dropped", 32'(Dropped), 32'b0100);
    Ack = 1'b1;
    tick();
    check("lit_d_chan", 32'(ChanOut), 32'h2);
    check("lit_d_timer", 32'(TimerOut), 32'd7);
    tick();

    // idle state with a one-cycle Inc pulse
    set_st(3, 2'b00);
    Inc[3] = 1'b1;
    tick();
    Inc[3] = 1'b0;
    hold(2);
    check("lit_e_chan", 32'(ChanOut), 32'h3);
    check("lit_e_timer", 32'(TimerOut), 32'd1);
    check("lit_e_drop_sticky", 32'(Dropped), 32'b0100);
    set_st(3, 2'b11);
    tick();

    // reset in the middle of a conversion discards it
    set_st(0, 2'b01);
    hold(2);
    Reset = 1'b1;
    model_reset();
    tick();
    set_st(0, 2'b11);
    Reset = 1'b0;
    hold(4);
    check("lit_f_ready", 32'(Ready), 32'h0);
    check("lit_f_timer", 32'(TimerOut), 32'h0);
    check("lit_f_drop", 32'(Dropped), 32'h0);

`ifdef SAR_TIMER_MAX_EN
    begin
      int durs [3];
      int maxs [3];
      durs = '{6, 3, 9};
      maxs = '{6, 6, 9};
      do_reset();
      Ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
        set_st(0, 2'b01);
        hold(durs[i]);
        set_st(0, 2'b11);
        hold(2);
        check("lit_g_timer", 32'(TimerOut), 32'(durs[i]));
        check("lit_g_max", 32'(MaxOut), 32'(maxs[i]));
        tick();
      end
    end
`endif

    // randomized phase
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 7) == 0) StateP[2*c +: 2] = 2'($urandom_range(0, 3));
      Inc = CH'($urandom & $urandom);
      Dcr = CH'($urandom & $urandom);
      Ack = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 599) == 0) begin
        Reset = 1'b1;
        model_reset();
        tick();
        Reset = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
